gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func: RTL and testbench

//  Parametrised, pipelined multi-channel OR-reduce with valid qualification and per-channel

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func_if.sv | 23 ++
 rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func.sv | 122 ++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func_if.sv
// Bus bundle for the pipelined OR-reduce aggregator: data/valid/clear in, reduced data, valid and counters out.
// STICKY exists only when GF180MCU_FD_SC_MCU7T5V0__ORN_PIPE_STICKY_EN is defined.
interface gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
);
    logic [WIDTH*CHANNELS-1:0] A;
    logic                      I_VLD;
    logic                      CLR;
    logic [CHANNELS-1:0]       Z;
    logic                      O_VLD;
    logic [CNT_W*CHANNELS-1:0] CNT;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ORN_PIPE_STICKY_EN
    logic [CHANNELS-1:0]       STICKY;

    modport master (output A, I_VLD, CLR, input Z, O_VLD, CNT, STICKY);
    modport slave  (input A, I_VLD, CLR, output Z, O_VLD, CNT, STICKY);
`else
    modport master (output A, I_VLD, CLR, input Z, O_VLD, CNT);
    modport slave  (input A, I_VLD, CLR, output Z, O_VLD, CNT);
`endif
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func.sv
// Multi-channel OR-reduce with STAGES-deep pipeline and saturating per-channel event counters.
// Optional sticky event flags: define GF180MCU_FD_SC_MCU7T5V0__ORN_PIPE_STICKY_EN.
module gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 1,
    parameter int CNT_W    = 8
) (
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func_if.slave bus
);

    if (WIDTH < 2 || CHANNELS < 1 || STAGES < 0 || STAGES > 4 || CNT_W < 2) begin : g_param_err
        $error("orn_pipe_func: parameter out of range");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic f_or_slice(input logic [WIDTH*CHANNELS-1:0] a, input int c);
        return |a[c*WIDTH +: WIDTH];
    endfunction

    logic [CHANNELS-1:0]       w_red;
    logic [CHANNELS-1:0]       w_z;
    logic                      w_vld;
    logic [CNT_W-1:0]          r_cnt [CHANNELS];
    logic [CNT_W*CHANNELS-1:0] w_cnt;

    // Per-channel OR reduction; X on any input is allowed to propagate.
    always_comb begin
        w_red = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_red[c] = f_or_slice(bus.A, c);
        end
    end

    if (STAGES == 0) begin : g_comb
        assign w_z   = w_red;
        assign w_vld = bus.I_VLD;
    end else begin : g_pipe
        logic [CHANNELS-1:0] r_data [STAGES];
        logic [STAGES-1:0]   r_vld;

        // Shift register for reduced data and valid; data loads every cycle regardless of valid.
        always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
                for (int s = 0; s < STAGES; s++) begin
                    r_data[s] <= '0;
                end
                r_vld <= '0;
            end else begin
                r_data[0] <= w_red;
                r_vld[0]  <= bus.I_VLD;
                for (int s = 1; s < STAGES; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_vld[s]  <= r_vld[s-1];
                end
            end
        end

        assign w_z   = r_data[STAGES-1];
        assign w_vld = r_vld[STAGES-1];
    end

    assign bus.Z     = w_z;
    assign bus.O_VLD = w_vld;

    // Saturating event counters; CLR wins over a same-edge event.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.CLR) begin
                    r_cnt[c] <= '0;
                end else if (w_vld && w_z[c] && (r_cnt[c] != CNT_MAX)) begin
                    r_cnt[c] <= r_cnt[c] + CNT_ONE;
                end else begin
                    r_cnt[c] <= r_cnt[c];
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        w_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_cnt[c*CNT_W +: CNT_W] = r_cnt[c];
        end
    end

    assign bus.CNT = w_cnt;

`ifdef GF180MCU_FD_SC_MCU7T5V0__ORN_PIPE_STICKY_EN
    logic [CHANNELS-1:0] r_sticky;

    // Sticky flags: a same-edge set beats CLR so no event is lost.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_sticky <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_vld && w_z[c]) begin
                    r_sticky[c] <= 1'b1;
                end else if (bus.CLR) begin
                    r_sticky[c] <= 1'b0;
                end else begin
                    r_sticky[c] <= r_sticky[c];
                end
            end
        end
    end

    assign bus.STICKY = r_sticky;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func.sv
// Bench: directed literal checks plus randomized traffic compared every cycle against a queue-based model.
module tb_gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func;
    localparam int W    = 4;
    localparam int CH   = 2;
    localparam int ST   = 2;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rn  = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) i2 ();
    gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(8))  i0 ();

    gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func #(.WIDTH(W), .CHANNELS(CH), .STAGES(ST), .CNT_W(CW)) u_dut2 (
        .CLK(clk), .RN(rn), .bus(i2));
    gf180mcu_fd_sc_mcu7t5v0__orn_pipe_func #(.WIDTH(W), .CHANNELS(CH), .STAGES(0), .CNT_W(8)) u_dut0 (
        .CLK(clk), .RN(rn), .bus(i0));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: a queue of {valid, reduced bits}, ST entries long.
    logic [CH:0] mq [$];
    logic [CH:0] m_out = '0;
    logic [CH:0] head;
    logic [CH:0] nxt;
    int          m_cnt [CH];
    logic [CH-1:0] m_sticky = '0;
    int          a_int;

    function automatic logic [CW*CH-1:0] m_cnt_flat();
        logic [CW*CH-1:0] f;
        f = '0;
        for (int c = 0; c < CH; c++) f = f | ((CW*CH)'(m_cnt[c]) << (c*CW));
        return f;
    endfunction

    always @(posedge clk or negedge rn) begin
        if (!rn) begin
            mq.delete();
            for (int s = 0; s < ST; s++) mq.push_back('0);
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
            m_sticky = '0;
            m_out = '0;
        end else begin
            head = mq[0];
            for (int c = 0; c < CH; c++) begin
                if (head[CH] && head[c]) m_sticky[c] = 1'b1;
                else if (i2.CLR) m_sticky[c] = 1'b0;
                if (i2.CLR) m_cnt[c] = 0;
                else if (head[CH] && head[c] && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            end
            a_int = int'(i2.A);
            nxt = '0;
            nxt[CH] = i2.I_VLD;
            for (int c = 0; c < CH; c++) nxt[c] = (((a_int >> (c*W)) & ((1 << W) - 1)) != 0);
            mq.push_back(nxt);
            void'(mq.pop_front());
            m_out = mq[0];
        end
    end

    // Per-cycle comparison of the pipelined DUT against the model.
    always @(negedge clk) begin
        chk("z", 64'(i2.Z), 64'(m_out[CH-1:0]));
        chk("o_vld", 64'(i2.O_VLD), 64'(m_out[CH]));
        chk("cnt", 64'(i2.CNT), 64'(m_cnt_flat()));
`ifdef GF180MCU_FD_SC_MCU7T5V0__ORN_PIPE_STICKY_EN
        chk("sticky", 64'(i2.STICKY), 64'(m_sticky));
`endif
    end

    int exp3 [10] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 7};

    initial begin
        i2.A = 8'hFF; i2.I_VLD = 1'b0; i2.CLR = 1'b0;
        i0.A = 8'h00; i0.I_VLD = 1'b0; i0.CLR = 1'b0;
        repeat (3) tick();
        chk("rst_z", 64'(i2.Z), 64'd0);
        chk("rst_cnt", 64'(i2.CNT), 64'd0);
        rn = 1'b1;
        // Inputs all ones but not valid: outputs must stay idle.
        repeat (4) begin
            tick();
            chk("idle_vld", 64'(i2.O_VLD), 64'd0);
            chk("idle_cnt", 64'(i2.CNT), 64'd0);
        end
        // Single event on channel 1, two-cycle latency.
        i2.A = 8'h10; i2.I_VLD = 1'b1;
        tick();
        i2.A = 8'h00; i2.I_VLD = 1'b0;
        chk("lat_vld_early", 64'(i2.O_VLD), 64'd0);
        tick();
        chk("lat_z", 64'(i2.Z), 64'd2);
        chk("lat_vld", 64'(i2.O_VLD), 64'd1);
        chk("lat_cnt_pre", 64'(i2.CNT), 64'd0);
        tick();
        chk("lat_cnt", 64'(i2.CNT), 64'h08);
        // Channel 0 held active: counter saturates at 7.
        i2.A = 8'h01; i2.I_VLD = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("sat_cnt0", 64'(i2.CNT[CW-1:0]), 64'(exp3[k]));
        end
        // CLR dominance over in-flight and same-edge events.
        i2.CLR = 1'b1; tick();
        chk("clr_cnt", 64'(i2.CNT), 64'd0);
        i2.CLR = 1'b0; tick();
        chk("clr_rel1", 64'(i2.CNT), 64'd1);
        tick();
        chk("clr_rel2", 64'(i2.CNT), 64'd2);
        i2.CLR = 1'b1; tick();
        chk("clr_same", 64'(i2.CNT), 64'd0);
`ifdef GF180MCU_FD_SC_MCU7T5V0__ORN_PIPE_STICKY_EN
        chk("sticky_set_wins", 64'(i2.STICKY), 64'd1);
`endif
        i2.CLR = 1'b0; i2.A = 8'h00; i2.I_VLD = 1'b0;
        repeat (3) tick();
        // Reset with valids in flight discards them.
        i2.A = 8'h11; i2.I_VLD = 1'b1;
        repeat (2) tick();
        rn = 1'b0; i2.A = 8'h00; i2.I_VLD = 1'b0;
        #1;
        chk("midrst_z", 64'(i2.Z), 64'd0);
        chk("midrst_vld", 64'(i2.O_VLD), 64'd0);
        chk("midrst_cnt", 64'(i2.CNT), 64'd0);
        tick();
        rn = 1'b1;
        repeat (3) begin
            tick();
            chk("postrst_vld", 64'(i2.O_VLD), 64'd0);
            chk("postrst_cnt", 64'(i2.CNT), 64'd0);
        end
        // Zero-stage instance: combinational Z, registered count.
        i0.I_VLD = 1'b1;
        #1;
        chk("s0_z_low", 64'(i0.Z), 64'd0);
        chk("s0_vld", 64'(i0.O_VLD), 64'd1);
        i0.A = 8'h02;
        #1;
        chk("s0_z_high", 64'(i0.Z), 64'd1);
        chk("s0_cnt_pre", 64'(i0.CNT), 64'd0);
        tick();
        i0.A = 8'h00; i0.I_VLD = 1'b0;
        chk("s0_cnt", 64'(i0.CNT), 64'h0001);
        tick();
        chk("s0_cnt_hold", 64'(i0.CNT), 64'h0001);
        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 3000; n++) begin
            i2.A     = (W*CH)'($urandom);
            i2.I_VLD = ($urandom_range(0, 9) < 7);
            i2.CLR   = ($urandom_range(0, 19) == 0);
            rn       = ($urandom_range(0, 199) != 0);
            tick();
        end
        rn = 1'b1;
        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
